// File: rtl/march_bist_ctrl.sv
// March C- MBIST sequencer for a single-port memory with 1-cycle write-data skew
// and 2-cycle read latency; reports pass/fail, first failing location and error count.
module march_bist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int ADDR_MAX   = 255,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREP, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ADDR_MAX);

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   addr, addr_nx, step, next_start;
  logic                    phase, phase_nx;
  logic                    up, at_end, adv, we, rd, clear;
  logic [2:0]              elem;
  logic [DATA_WIDTH-1:0]   wval, exp_val;

  logic                    p1_valid, p2_valid;
  logic [DATA_WIDTH-1:0]   p1_exp, p2_exp;
  logic [ADDR_WIDTH-1:0]   p1_addr, p2_addr;
  logic [2:0]              p1_elem, p2_elem;
  logic                    mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      addr  <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      phase <= phase_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    addr_nx    = addr;
    phase_nx   = phase;
    we         = 1'b0;
    rd         = 1'b0;
    adv        = 1'b0;
    clear      = 1'b0;
    elem       = 3'd0;
    up         = !(state == S_M3 || state == S_M4);
    at_end     = up ? (addr == LAST) : (addr == '0);
    step       = up ? addr + ADDR_WIDTH'(1) : addr - ADDR_WIDTH'(1);
    next_start = (state == S_M2 || state == S_M3) ? LAST : '0;
    // Write data leads its write by one cycle, so it is set per element, not per op.
    wval       = (state == S_M1 || state == S_M3) ? '1 : '0;
    exp_val    = (state == S_M2 || state == S_M4) ? '1 : '0;

    case (state)
      S_IDLE:  if (start) begin state_nx = S_PREP; clear = 1'b1; end
      S_PREP:  begin state_nx = S_M0; addr_nx = '0; phase_nx = 1'b0; end
      S_M0:    begin we = 1'b1; adv = 1'b1; end
      S_M1, S_M2, S_M3, S_M4: begin
        if (!phase) begin
          rd = 1'b1;
          phase_nx = 1'b1;
        end else begin
          we = 1'b1;
          phase_nx = 1'b0;
          adv = 1'b1;
        end
      end
      S_M5:    begin rd = 1'b1; adv = 1'b1; end
      S_DRAIN: begin
        phase_nx = ~phase;
        if (phase) state_nx = S_DONE;
      end
      S_DONE:  if (start) begin state_nx = S_PREP; clear = 1'b1; end
      default: state_nx = S_IDLE;
    endcase

    case (state)
      S_M1: elem = 3'd1;
      S_M2: elem = 3'd2;
      S_M3: elem = 3'd3;
      S_M4: elem = 3'd4;
      S_M5: elem = 3'd5;
      default: elem = 3'd0;
    endcase

    if (adv) begin
      if (at_end) begin
        state_nx = state_t'(state + 4'd1);
        addr_nx  = next_start;
      end else begin
        addr_nx  = step;
      end
    end
  end

  assign busy           = !(state == S_IDLE || state == S_DONE);
  assign done           = (state == S_DONE);
  assign mem_write_read = we;
  assign mem_address    = addr;
  assign mem_wdata      = (state >= S_M0 && state <= S_M5) ? wval : '0;

  // Read context travels alongside the memory's two-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0; p1_exp <= '0; p1_addr <= '0; p1_elem <= '0;
      p2_valid <= 1'b0; p2_exp <= '0; p2_addr <= '0; p2_elem <= '0;
    end else begin
      p1_valid <= rd;       p1_exp <= exp_val; p1_addr <= addr;    p1_elem <= elem;
      p2_valid <= p1_valid; p2_exp <= p1_exp;  p2_addr <= p1_addr; p2_elem <= p1_elem;
    end
  end

  assign mismatch = p2_valid && (mem_rdata != p2_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail         <= 1'b0;
      fail_addr    <= '0;
      fail_element <= '0;
      fail_count   <= '0;
    end else if (clear) begin
      fail         <= 1'b0;
      fail_addr    <= '0;
      fail_element <= '0;
      fail_count   <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (!fail) begin
        fail_addr    <= p2_addr;
        fail_element <= p2_elem;
      end
      if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl: behavioural fault_mem model with injectable
// faults, bus-trace check against the March C- op list, timing and fail reporting.
module tb_march_bist_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, start2 = 1'b0;
  logic       busy, done, fail, mem_write_read;
  logic [7:0] fail_addr, mem_address, mem_wdata, mem_rdata;
  logic [2:0] fail_element;
  logic [7:0] fail_count;

  logic       busy2, done2, fail2, mem_write_read2;
  logic [7:0] fail_addr2, mem_address2, mem_wdata2;
  logic [2:0] fail_element2, fail_count2;
  logic [7:0] rdata_ff = 8'hFF;

  int n_cmp = 0, n_bad = 0;
  int mode = 0;  // 0 fault-free, 1 addr5 bit3 stuck-at-0, 2 all reads 0xFF

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  march_bist_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .ADDR_MAX(7), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_element(fail_element), .fail_count(fail_count),
    .mem_write_read(mem_write_read), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  march_bist_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .ADDR_MAX(7), .CNT_WIDTH(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .fail(fail2),
    .fail_addr(fail_addr2), .fail_element(fail_element2), .fail_count(fail_count2),
    .mem_write_read(mem_write_read2), .mem_address(mem_address2), .mem_wdata(mem_wdata2),
    .mem_rdata(rdata_ff));

  // fault_mem model: wdata registered one cycle ahead of its write, reads return after 2 cycles
  logic [7:0] mem_arr [8];
  logic [7:0] wd_q, rd1, rd_val;
  always_comb begin
    rd_val = mem_arr[mem_address[2:0]];
    if (mode == 1 && mem_address == 8'd5) rd_val = rd_val & 8'hF7;
    if (mode == 2) rd_val = 8'hFF;
  end
  always @(posedge clk) begin
    wd_q <= mem_wdata;
    if (mem_write_read) mem_arr[mem_address[2:0]] <= wd_q;
    rd1 <= rd_val;
    mem_rdata <= rd1;
  end

  // bus trace, one entry per cycle starting with the PREP cycle
  logic       rec_en = 1'b0;
  int         n_tr = 0;
  logic       tr_we [100];
  logic [7:0] tr_addr [100];
  logic [7:0] tr_wd [100];
  always @(negedge clk) begin
    if (rec_en && n_tr < 100) begin
      tr_we[n_tr]   <= mem_write_read;
      tr_addr[n_tr] <= mem_address;
      tr_wd[n_tr]   <= mem_wdata;
      n_tr <= n_tr + 1;
    end
  end

  int edges, busy_n;

  task automatic kick(input bit both, input bit rec);
    @(negedge clk);
    start = 1'b1;
    start2 = both;
    @(posedge clk);
    #1;
    start = 1'b0;
    start2 = 1'b0;
    if (rec) begin n_tr = 0; rec_en = 1'b1; end
  endtask

  task automatic wait_done(input bit poke_start);
    edges = 0;
    busy_n = busy ? 1 : 0;
    while (edges < 2000) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_n++;
      if (poke_start && edges == 20) start = 1'b1;
      if (edges == 21) start = 1'b0;
      if (done) break;
    end
    rec_en = 1'b0;
    chk("done_within_bound", done, 1'b1);
  endtask

  logic       e_we [80];
  logic [7:0] e_addr [80];
  logic [7:0] e_wd [80];

  initial begin
    int k;
    logic [7:0] a;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fail", fail, 1'b0);
    chk("rst_fail_addr", fail_addr, 8'd0);
    chk("rst_fail_element", fail_element, 3'd0);
    chk("rst_fail_count", fail_count, 8'd0);
    chk("rst_we", mem_write_read, 1'b0);
    chk("rst_addr", mem_address, 8'd0);
    chk("rst_wdata", mem_wdata, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // expected March C- op list for N=8
    k = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 8; i++) begin
        a = (e == 3 || e == 4) ? 8'(7 - i) : 8'(i);
        if (e == 0) begin
          e_we[k] = 1'b1; e_addr[k] = a; e_wd[k] = 8'h00; k++;
        end else begin
          e_we[k] = 1'b0; e_addr[k] = a; e_wd[k] = 8'h00; k++;
          if (e <= 4) begin
            e_we[k] = 1'b1; e_addr[k] = a;
            e_wd[k] = (e == 1 || e == 3) ? 8'hFF : 8'h00; k++;
          end
        end
      end
    end

    // fault-free run: timing, result and bus trace
    mode = 0;
    kick(1'b0, 1'b1);
    chk("busy_after_start", busy, 1'b1);
    wait_done(1'b0);
    chk("good_edges", edges, 83);
    chk("good_busy_cycles", busy_n, 83);
    chk("good_busy_at_done", busy, 1'b0);
    chk("good_fail", fail, 1'b0);
    chk("good_fail_count", fail_count, 8'd0);
    chk("done_we_read_only", mem_write_read, 1'b0);
    chk("trace_len", n_tr >= 83, 1'b1);
    chk("prep_we", tr_we[0], 1'b0);
    chk("prep_wdata", tr_wd[0], 8'h00);
    for (int i = 0; i < 80; i++) begin
      chk("bus_we", tr_we[i+1], e_we[i]);
      chk("bus_addr", tr_addr[i+1], e_addr[i]);
      if (e_we[i]) chk("bus_wdata_lead", tr_wd[i], e_wd[i]);
    end
    chk("drain_we0", tr_we[81], 1'b0);
    chk("drain_we1", tr_we[82], 1'b0);

    // stuck-at-0 on bit 3 of address 5
    mode = 1;
    kick(1'b0, 1'b0);
    wait_done(1'b0);
    chk("sa0_fail", fail, 1'b1);
    chk("sa0_fail_addr", fail_addr, 8'd5);
    chk("sa0_fail_element", fail_element, 3'd2);
    chk("sa0_fail_count", fail_count, 8'd2);

    // all reads 0xFF; second instance has a 3-bit counter
    mode = 2;
    kick(1'b1, 1'b0);
    wait_done(1'b0);
    chk("ff_fail", fail, 1'b1);
    chk("ff_fail_addr", fail_addr, 8'd0);
    chk("ff_fail_element", fail_element, 3'd1);
    chk("ff_fail_count", fail_count, 8'd24);
    chk("sat_done", done2, 1'b1);
    chk("sat_fail", fail2, 1'b1);
    chk("sat_fail_addr", fail_addr2, 8'd0);
    chk("sat_fail_element", fail_element2, 3'd1);
    chk("sat_fail_count", fail_count2, 3'd7);

    // reset in the middle of M3, then a full clean rerun
    mode = 0;
    kick(1'b0, 1'b0);
    repeat (45) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_fail", fail, 1'b0);
    chk("midrst_we", mem_write_read, 1'b0);
    chk("midrst_addr", mem_address, 8'd0);
    chk("midrst_wdata", mem_wdata, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(1'b0, 1'b0);
    wait_done(1'b0);
    chk("rerun_edges", edges, 83);
    chk("rerun_fail", fail, 1'b0);

    // start during busy ignored; start in DONE after failure clears and restarts
    mode = 1;
    kick(1'b0, 1'b0);
    wait_done(1'b1);
    chk("ignored_start_edges", edges, 83);
    chk("ignored_start_fail", fail, 1'b1);
    chk("ignored_start_count", fail_count, 8'd2);
    mode = 0;
    kick(1'b0, 1'b0);
    chk("restart_done_clr", done, 1'b0);
    chk("restart_busy", busy, 1'b1);
    chk("restart_fail_clr", fail, 1'b0);
    chk("restart_count_clr", fail_count, 8'd0);
    chk("restart_elem_clr", fail_element, 3'd0);
    @(negedge clk);
    chk("restart_prep_we", mem_write_read, 1'b0);
    wait_done(1'b0);
    chk("restart_edges", edges, 83);
    chk("restart_fail", fail, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
